// File: rtl/slice_stream_reader.sv
// Streams one 30-bit driver word per driver_ready pop from slice RAM via a 2-entry prefetch FIFO.
// Latency: first ram_rd 1 cycle after position_sync; head word valid 3 cycles after position_sync.
// Backpressure: reads are issued only while FIFO + in-flight < 2, counting a same-cycle pop as free space.
module slice_stream_reader #(
  parameter int WORDS_PER_MUX = 432,
  parameter int NB_MUX        = 8,
  parameter int NB_SLICES     = 128,
  parameter int ADDR_W        = 21
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              position_sync,
  input  logic              bank_sel,
  input  logic              driver_ready,
  input  logic              column_ready,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [29:0]       ram_rdata,
  output logic [29:0]       framebuffer_dat,
  output logic [6:0]        slice_idx,
  output logic              underrun,
  output logic              misalign
);

  localparam int OFF_W = ADDR_W - 1;
  localparam int WRD_W = $clog2(WORDS_PER_MUX);
  localparam int MUX_W = (NB_MUX > 1) ? $clog2(NB_MUX) : 1;
  localparam int PC_W  = $clog2(WORDS_PER_MUX + 1) + 1;

  localparam logic [OFF_W-1:0] ROW_STEP   = OFF_W'(WORDS_PER_MUX);
  localparam logic [OFF_W-1:0] SLICE_STEP = OFF_W'(NB_MUX * WORDS_PER_MUX);
  localparam logic [WRD_W-1:0] LAST_WORD  = WRD_W'(WORDS_PER_MUX - 1);
  localparam logic [MUX_W-1:0] LAST_MUX   = MUX_W'(NB_MUX - 1);
  localparam logic [6:0]       LAST_SLICE = 7'(NB_SLICES - 1);
  localparam logic [PC_W-1:0]  ROW_POPS   = PC_W'(WORDS_PER_MUX);
  localparam logic [PC_W-1:0]  PC_MAX     = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_bank;
  logic             r_synced;
  logic [6:0]       r_slice_idx;
  logic [OFF_W-1:0] r_slice_base;
  logic [OFF_W-1:0] r_row_base;
  logic [MUX_W-1:0] r_mux;
  logic [WRD_W-1:0] r_rd_word;
  logic             r_row_end;
  logic [PC_W-1:0]  r_pop_cnt;
  logic [1:0]       r_cnt;
  logic [29:0]      r_q0;
  logic [29:0]      r_q1;
  logic             r_inflight;
  logic             r_underrun;
  logic             r_misalign;

  logic             w_col_ev;
  logic             w_flush;
  logic             w_pop;
  logic             w_underrun_ev;
  logic             w_wr;
  logic [1:0]       w_used;
  logic [PC_W-1:0]  w_pop_total;
  logic [6:0]       w_next_idx;
  logic [OFF_W-1:0] w_next_base;

  // Event decode: sync wins over column_ready and pops; column_ready only matters while streaming.
  always_comb begin
    w_col_ev      = column_ready && (r_state == S_RUN) && !position_sync;
    w_flush       = position_sync || w_col_ev;
    w_pop         = driver_ready && (r_cnt != 2'd0) && !position_sync;
    w_underrun_ev = driver_ready && (r_cnt == 2'd0) && !position_sync;
    w_wr          = r_inflight && !w_flush;
    w_used        = (r_cnt - {1'b0, w_pop}) + {1'b0, r_inflight};
    w_pop_total   = (r_pop_cnt == PC_MAX) ? PC_MAX : r_pop_cnt + PC_W'(w_pop);
    if (!r_synced) begin
      w_next_idx  = r_slice_idx;
      w_next_base = r_slice_base;
    end else if (r_slice_idx == LAST_SLICE) begin
      w_next_idx  = 7'd0;
      w_next_base = '0;
    end else begin
      w_next_idx  = r_slice_idx + 7'd1;
      w_next_base = r_slice_base + SLICE_STEP;
    end
  end

  assign ram_rd          = (r_state == S_RUN) && !r_row_end && !w_flush && (w_used < 2'd2);
  assign ram_addr        = {r_bank, r_row_base + OFF_W'(r_rd_word)};
  assign framebuffer_dat = (r_cnt != 2'd0) ? r_q0 : 30'd0;
  assign slice_idx       = r_slice_idx;
  assign underrun        = r_underrun;
  assign misalign        = r_misalign;

  // Sequencing: slice/row accumulators, read pointer and per-row pop count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_bank       <= 1'b0;
      r_synced     <= 1'b0;
      r_slice_idx  <= 7'd0;
      r_slice_base <= '0;
      r_row_base   <= '0;
      r_mux        <= '0;
      r_rd_word    <= '0;
      r_row_end    <= 1'b0;
      r_pop_cnt    <= '0;
    end else if (position_sync) begin
      r_state      <= S_RUN;
      r_bank       <= bank_sel;
      r_synced     <= 1'b1;
      r_slice_idx  <= w_next_idx;
      r_slice_base <= w_next_base;
      r_row_base   <= w_next_base;
      r_mux        <= '0;
      r_rd_word    <= '0;
      r_row_end    <= 1'b0;
      r_pop_cnt    <= '0;
    end else if (w_col_ev) begin
      r_rd_word <= '0;
      r_row_end <= 1'b0;
      r_pop_cnt <= '0;
      if (r_mux == LAST_MUX) begin
        r_state <= S_DONE;
      end else begin
        r_mux      <= r_mux + MUX_W'(1);
        r_row_base <= r_row_base + ROW_STEP;
      end
    end else begin
      if (ram_rd) begin
        if (r_rd_word == LAST_WORD) r_row_end <= 1'b1;
        else                        r_rd_word <= r_rd_word + WRD_W'(1);
      end
      if (w_pop && (r_pop_cnt != PC_MAX)) r_pop_cnt <= r_pop_cnt + PC_W'(1);
    end
  end

  // Prefetch FIFO: head in r_q0, RAM return written one cycle after its read, dropped on flush.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt      <= 2'd0;
      r_q0       <= 30'd0;
      r_q1       <= 30'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= ram_rd;
      if (w_flush) begin
        r_cnt <= 2'd0;
      end else begin
        case ({w_wr, w_pop})
          2'b10: begin
            if (r_cnt == 2'd0) r_q0 <= ram_rdata;
            else               r_q1 <= ram_rdata;
            r_cnt <= r_cnt + 2'd1;
          end
          2'b01: begin
            r_q0  <= r_q1;
            r_cnt <= r_cnt - 2'd1;
          end
          2'b11: begin
            if (r_cnt == 2'd1) begin
              r_q0 <= ram_rdata;
            end else begin
              r_q0 <= r_q1;
              r_q1 <= ram_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_underrun <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_underrun_ev) r_underrun <= 1'b1;
      if (w_col_ev && (w_pop_total != ROW_POPS)) r_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slice_stream_reader.sv
// Directed bench for slice_stream_reader: RAM model returns its own address one cycle after ram_rd.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_slice_stream_reader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        position_sync;
  logic        bank_sel;
  logic        driver_ready;
  logic        column_ready;
  logic        ram_rd;
  logic [20:0] ram_addr;
  logic [29:0] ram_rdata = 30'd0;
  logic [29:0] framebuffer_dat;
  logic [6:0]  slice_idx;
  logic        underrun;
  logic        misalign;

  int n_cmp  = 0;
  int n_fail = 0;

  slice_stream_reader dut (
    .clk             (clk),
    .nrst            (nrst),
    .position_sync   (position_sync),
    .bank_sel        (bank_sel),
    .driver_ready    (driver_ready),
    .column_ready    (column_ready),
    .ram_rd          (ram_rd),
    .ram_addr        (ram_addr),
    .ram_rdata       (ram_rdata),
    .framebuffer_dat (framebuffer_dat),
    .slice_idx       (slice_idx),
    .underrun        (underrun),
    .misalign        (misalign)
  );

  always #5 clk = ~clk;

  // RAM content equals its address.
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= {9'd0, ram_addr};
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    nrst          = 1'b0;
    position_sync = 1'b0;
    bank_sel      = 1'b0;
    driver_ready  = 1'b0;
    column_ready  = 1'b0;
    step;
    step;
    nrst = 1'b1;
    step;
  endtask

  // Caller has driven the row-start event in the current cycle. Streams npops words,
  // then leaves column_ready driven in the current cycle.
  task automatic stream_row(input logic [20:0] base, input int npops);
    step;
    position_sync = 1'b0;
    column_ready  = 1'b0;
    driver_ready  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_rd, ram_addr} !== {1'b1, base}) begin
      n_fail++;
      $display("FAIL row_first_read: rd=%0b addr=%h, want rd=1 addr=%h", ram_rd, ram_addr, base);
    end
    step;
    step;
    driver_ready = 1'b1;
    for (int k = 0; k < npops; k++) begin
      @(negedge clk);
      n_cmp++;
      if (framebuffer_dat !== ({9'd0, base} + 30'(k))) begin
        n_fail++;
        $display("FAIL row_word[%0d]: got %h, want %h", k, framebuffer_dat, {9'd0, base} + 30'(k));
      end
      step;
    end
    driver_ready = 1'b0;
    column_ready = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign} !== 61'd0) begin
        n_fail++;
        $display("FAIL reset_state: rd=%0b addr=%h dat=%h idx=%0d ur=%0b ma=%0b, want all 0",
                 ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign);
      end
      step;
    end
  endtask

  task automatic test_first_read;
    do_reset;
    bank_sel      = 1'b1;
    position_sync = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_no_read_at_sync: rd=%0b, want 0", ram_rd);
    end
    step;
    position_sync = 1'b0;
    bank_sel      = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_rd, ram_addr} !== {1'b1, 21'h100000}) begin
      n_fail++;
      $display("FAIL t1_first_read: rd=%0b addr=%h, want rd=1 addr=100000", ram_rd, ram_addr);
    end
    step;
    @(negedge clk);
    n_cmp++;
    if (framebuffer_dat !== 30'd0) begin
      n_fail++;
      $display("FAIL t1_dat_t2: got %h, want 0", framebuffer_dat);
    end
    step;
    @(negedge clk);
    n_cmp++;
    if (framebuffer_dat !== 30'h100000) begin
      n_fail++;
      $display("FAIL t1_dat_t3: got %h, want 100000", framebuffer_dat);
    end
  endtask

  task automatic test_row_stream;
    do_reset;
    position_sync = 1'b1;
    stream_row(21'd0, 432);
    @(negedge clk);
    n_cmp++;
    if ({framebuffer_dat, underrun} !== 31'd0) begin
      n_fail++;
      $display("FAIL t2_row_end: dat=%h ur=%0b, want dat=0 ur=0", framebuffer_dat, underrun);
    end
    step;
    column_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_rd, ram_addr, misalign} !== {1'b1, 21'd432, 1'b0}) begin
      n_fail++;
      $display("FAIL t2_next_row: rd=%0b addr=%0d ma=%0b, want rd=1 addr=432 ma=0", ram_rd, ram_addr, misalign);
    end
  endtask

  task automatic test_full_slice;
    do_reset;
    position_sync = 1'b1;
    for (int r = 0; r < 8; r++) stream_row(21'(r * 432), 432);
    step;
    column_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({ram_rd, framebuffer_dat} !== 31'd0) begin
        n_fail++;
        $display("FAIL t3_done_idle: rd=%0b dat=%h, want rd=0 dat=0", ram_rd, framebuffer_dat);
      end
      step;
    end
    column_ready = 1'b1;
    step;
    column_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({misalign, underrun, ram_rd} !== 3'b000) begin
      n_fail++;
      $display("FAIL t3_done_col_ignored: ma=%0b ur=%0b rd=%0b, want 0 0 0", misalign, underrun, ram_rd);
    end
    step;
    position_sync = 1'b1;
    step;
    position_sync = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_rd, ram_addr, slice_idx} !== {1'b1, 21'd3456, 7'd1}) begin
      n_fail++;
      $display("FAIL t3_second_slice: rd=%0b addr=%0d idx=%0d, want rd=1 addr=3456 idx=1", ram_rd, ram_addr, slice_idx);
    end
  endtask

  task automatic test_slice_wrap;
    do_reset;
    for (int i = 0; i <= 128; i++) begin
      position_sync = 1'b1;
      step;
      position_sync = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ram_rd, ram_addr, slice_idx} !== {1'b1, 21'((i % 128) * 3456), 7'(i % 128)}) begin
        n_fail++;
        $display("FAIL t4_sync[%0d]: rd=%0b addr=%0d idx=%0d, want rd=1 addr=%0d idx=%0d",
                 i, ram_rd, ram_addr, slice_idx, (i % 128) * 3456, i % 128);
      end
      step;
    end
  endtask

  task automatic test_underrun;
    do_reset;
    bank_sel      = 1'b1;
    position_sync = 1'b1;
    step;
    position_sync = 1'b0;
    driver_ready  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({framebuffer_dat, underrun} !== 31'd0) begin
      n_fail++;
      $display("FAIL t5_t1: dat=%h ur=%0b, want dat=0 ur=0", framebuffer_dat, underrun);
    end
    step;
    @(negedge clk);
    n_cmp++;
    if ({framebuffer_dat, underrun} !== {30'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL t5_t2: dat=%h ur=%0b, want dat=0 ur=1", framebuffer_dat, underrun);
    end
    step;
    @(negedge clk);
    n_cmp++;
    if (framebuffer_dat !== 30'h100000) begin
      n_fail++;
      $display("FAIL t5_t3: dat=%h, want 100000", framebuffer_dat);
    end
    step;
    @(negedge clk);
    n_cmp++;
    if ({framebuffer_dat, underrun} !== {30'h100001, 1'b1}) begin
      n_fail++;
      $display("FAIL t5_t4: dat=%h ur=%0b, want dat=100001 ur=1", framebuffer_dat, underrun);
    end
    driver_ready = 1'b0;
  endtask

  task automatic test_misalign;
    do_reset;
    position_sync = 1'b1;
    stream_row(21'd0, 400);
    @(negedge clk);
    n_cmp++;
    if (misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_before: ma=%0b, want 0", misalign);
    end
    step;
    column_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({misalign, ram_rd, ram_addr, underrun} !== {1'b1, 1'b1, 21'd432, 1'b0}) begin
      n_fail++;
      $display("FAIL t6_after: ma=%0b rd=%0b addr=%0d ur=%0b, want ma=1 rd=1 addr=432 ur=0",
               misalign, ram_rd, ram_addr, underrun);
    end
  endtask

  task automatic test_sync_collision;
    do_reset;
    position_sync = 1'b1;
    step;
    position_sync = 1'b0;
    step;
    step;
    driver_ready = 1'b1;
    repeat (5) step;
    position_sync = 1'b1;
    column_ready  = 1'b1;
    stream_row(21'd3456, 432);
    step;
    column_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({misalign, underrun, slice_idx} !== {1'b0, 1'b0, 7'd1}) begin
      n_fail++;
      $display("FAIL t7_collision: ma=%0b ur=%0b idx=%0d, want ma=0 ur=0 idx=1", misalign, underrun, slice_idx);
    end
  endtask

  task automatic test_reset_mid_stream;
    do_reset;
    bank_sel      = 1'b1;
    position_sync = 1'b1;
    step;
    position_sync = 1'b0;
    step;
    position_sync = 1'b1;
    step;
    position_sync = 1'b0;
    driver_ready  = 1'b1;
    repeat (5) step;
    driver_ready = 1'b0;
    column_ready = 1'b1;
    step;
    column_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({underrun, misalign, slice_idx, ram_rd} !== {1'b1, 1'b1, 7'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL t8_pre: ur=%0b ma=%0b idx=%0d rd=%0b, want 1 1 1 1", underrun, misalign, slice_idx, ram_rd);
    end
    step;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign} !== 61'd0) begin
      n_fail++;
      $display("FAIL t8_in_reset: rd=%0b addr=%h dat=%h idx=%0d ur=%0b ma=%0b, want all 0",
               ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign);
    end
    step;
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign} !== 61'd0) begin
        n_fail++;
        $display("FAIL t8_after_reset: rd=%0b addr=%h dat=%h idx=%0d ur=%0b ma=%0b, want all 0",
                 ram_rd, ram_addr, framebuffer_dat, slice_idx, underrun, misalign);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_first_read;
    test_row_stream;
    test_full_slice;
    test_slice_wrap;
    test_underrun;
    test_misalign;
    test_sync_collision;
    test_reset_mid_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
